// File: rtl/safety_island_pkg.sv
// Shared types and constants for the safety island isolation sequencer.
package safety_island_pkg;

    localparam int unsigned IsolateTimeoutDefault = 32'd1024;

    typedef enum logic [2:0] {
        ST_CONNECTED = 3'd0,
        ST_ISOLATING = 3'd1,
        ST_ISOLATED  = 3'd2,
        ST_RELEASING = 3'd3,
        ST_TIMEOUT   = 3'd4
    } isolate_state_e;

    // TIMEOUT and any unknown encoding keep the bus isolated (fail-safe).
    function automatic logic drives_isolate(input isolate_state_e s);
        case (s)
            ST_CONNECTED, ST_RELEASING: return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

    function automatic logic is_busy(input isolate_state_e s);
        case (s)
            ST_ISOLATING, ST_RELEASING: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/safety_island_isolate_ctrl_if.sv
// Request/status and wrapper-handshake bundle of the isolation sequencer.
interface safety_island_isolate_ctrl_if;
    logic       sw_isolate_i;
    logic       hw_fault_i;
    logic       clear_i;
    logic       isolated_i;
    logic       isolate_o;
    logic       isolated_o;
    logic       busy_o;
    logic       error_o;
    logic [2:0] state_o;
    logic       done_irq_o;
    logic       err_irq_o;

    modport slave (
        input  sw_isolate_i, hw_fault_i, clear_i, isolated_i,
        output isolate_o, isolated_o, busy_o, error_o, state_o, done_irq_o, err_irq_o
    );

    modport master (
        output sw_isolate_i, hw_fault_i, clear_i, isolated_i,
        input  isolate_o, isolated_o, busy_o, error_o, state_o, done_irq_o, err_irq_o
    );
endinterface

// File: rtl/safety_island_phase_timer.sv
// Saturating phase counter; expired_o flags the last allowed cycle of a phase.
module safety_island_phase_timer #(
    parameter int unsigned TimeoutCycles = 32'd1024,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 32'd1);

    logic [CntWidth-1:0] cnt_r;

    // Count enabled cycles, holding at the last value until cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CntWidth{1'b0}};
        end else if (en_i && (cnt_r != LastCnt)) begin
            cnt_r <= cnt_r + CntWidth'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = (cnt_r == LastCnt);

endmodule

// File: rtl/safety_island_isolate_ctrl.sv
// Sequences the safety island AXI isolate/release handshake with per-phase timeout.
module safety_island_isolate_ctrl
    import safety_island_pkg::*;
#(
    parameter int unsigned TimeoutCycles = IsolateTimeoutDefault,
    parameter int unsigned CntWidth      = $clog2(TimeoutCycles),
    parameter logic        ResetIsolated = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    safety_island_isolate_ctrl_if.slave  bus
);

    localparam isolate_state_e ResetState = ResetIsolated ? ST_ISOLATING : ST_CONNECTED;

    isolate_state_e state_r;
    isolate_state_e next_state_s;
    logic           fault_r;
    logic           fault_next_s;
    logic           req_s;
    logic           req_after_clear_s;
    logic           expired_s;
    logic           phase_clr_s;
    logic           phase_en_s;
    logic           isolate_r;
    logic           isolated_r;
    logic           busy_r;
    logic           error_r;
    logic           done_irq_r;
    logic           err_irq_r;

    // Sticky fault latch input: a new fault always beats a clear.
    always_comb begin
        fault_next_s = fault_r;
        if (bus.hw_fault_i) begin
            fault_next_s = 1'b1;
        end else if (bus.clear_i) begin
            fault_next_s = 1'b0;
        end else begin
            fault_next_s = fault_r;
        end
    end

    assign req_s             = bus.sw_isolate_i | fault_r;
    assign req_after_clear_s = bus.sw_isolate_i | fault_next_s;

    // Next-state selection; an unexpected drop of isolated_i while isolated is an error.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_CONNECTED: begin
                if (req_s) next_state_s = ST_ISOLATING;
                else       next_state_s = ST_CONNECTED;
            end
            ST_ISOLATING: begin
                if (bus.isolated_i)  next_state_s = ST_ISOLATED;
                else if (expired_s)  next_state_s = ST_TIMEOUT;
                else                 next_state_s = ST_ISOLATING;
            end
            ST_ISOLATED: begin
                if (!bus.isolated_i) next_state_s = ST_TIMEOUT;
                else if (!req_s)     next_state_s = ST_RELEASING;
                else                 next_state_s = ST_ISOLATED;
            end
            ST_RELEASING: begin
                if (!bus.isolated_i) next_state_s = ST_CONNECTED;
                else if (expired_s)  next_state_s = ST_TIMEOUT;
                else                 next_state_s = ST_RELEASING;
            end
            ST_TIMEOUT: begin
                if (bus.clear_i) begin
                    if (req_after_clear_s) next_state_s = ST_ISOLATING;
                    else                   next_state_s = ST_RELEASING;
                end else begin
                    next_state_s = ST_TIMEOUT;
                end
            end
            default: next_state_s = ST_TIMEOUT;
        endcase
    end

    assign phase_clr_s = (next_state_s != state_r);
    assign phase_en_s  = is_busy(state_r);

    safety_island_phase_timer #(
        .TimeoutCycles (TimeoutCycles),
        .CntWidth      (CntWidth)
    ) u_phase_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (phase_clr_s),
        .en_i      (phase_en_s),
        .expired_o (expired_s)
    );

    // State, fault latch and all outputs are registered from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ResetState;
            fault_r    <= 1'b0;
            isolate_r  <= ResetIsolated;
            isolated_r <= 1'b0;
            busy_r     <= ResetIsolated;
            error_r    <= 1'b0;
            done_irq_r <= 1'b0;
            err_irq_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            fault_r    <= fault_next_s;
            isolate_r  <= drives_isolate(next_state_s);
            isolated_r <= (next_state_s == ST_ISOLATED);
            busy_r     <= is_busy(next_state_s);
            error_r    <= (next_state_s == ST_TIMEOUT);
            done_irq_r <= ((state_r == ST_ISOLATING) && (next_state_s == ST_ISOLATED)) ||
                          ((state_r == ST_RELEASING) && (next_state_s == ST_CONNECTED));
            err_irq_r  <= (next_state_s == ST_TIMEOUT) && (state_r != ST_TIMEOUT);
        end
    end

    assign bus.isolate_o  = isolate_r;
    assign bus.isolated_o = isolated_r;
    assign bus.busy_o     = busy_r;
    assign bus.error_o    = error_r;
    assign bus.state_o    = state_r;
    assign bus.done_irq_o = done_irq_r;
    assign bus.err_irq_o  = err_irq_r;

endmodule

// File: tb/tb_safety_island_isolate_ctrl.sv
// Randomized scoreboard bench for the isolation sequencer against a cycle-level reference model.
module tb_safety_island_isolate_ctrl;

    localparam int T = 16;

    logic clk;
    logic rst;
    logic rst2;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    safety_island_isolate_ctrl_if bus ();
    safety_island_isolate_ctrl_if bus2 ();

    safety_island_isolate_ctrl #(.TimeoutCycles(T), .ResetIsolated(1'b0)) dut (
        .clk_i (clk), .rst_i (rst), .bus (bus)
    );

    safety_island_isolate_ctrl #(.TimeoutCycles(T), .ResetIsolated(1'b1)) dut_ri (
        .clk_i (clk), .rst_i (rst2), .bus (bus2)
    );

    typedef struct {
        int       cyc;
        int       st;
        bit       iso, isd, busy, err, done, eirq;
    } exp_t;
    exp_t q[$];

    // Reference model: mode uses the status encodings, age counts cycles spent in the mode.
    int m_mode;
    int m_age;
    bit m_fault;

    // Wrapper model: follows isolate_o after w_delay cycles when w_auto is set.
    bit w_auto;
    int w_delay;
    int w_cnt;
    bit w_iso;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input bit sw, input bit hw, input bit clr, input bit iso,
                              input bit r, output exp_t e);
        int nm;
        bit req, fnext;
        e.done = 1'b0;
        e.eirq = 1'b0;
        if (r) begin
            m_mode = 0; m_age = 1; m_fault = 1'b0;
            nm = 0;
        end else begin
            req   = sw | m_fault;
            fnext = hw ? 1'b1 : (clr ? 1'b0 : m_fault);
            nm    = m_mode;
            if (m_mode == 0) begin
                if (req) nm = 1;
            end else if (m_mode == 1) begin
                if (iso) begin nm = 2; e.done = 1'b1; end
                else if (m_age >= T) begin nm = 4; e.eirq = 1'b1; end
            end else if (m_mode == 2) begin
                if (!iso) begin nm = 4; e.eirq = 1'b1; end
                else if (!req) nm = 3;
            end else if (m_mode == 3) begin
                if (!iso) begin nm = 0; e.done = 1'b1; end
                else if (m_age >= T) begin nm = 4; e.eirq = 1'b1; end
            end else begin
                if (clr) nm = (sw | fnext) ? 1 : 3;
            end
            m_age   = (nm != m_mode) ? 1 : m_age + 1;
            m_mode  = nm;
            m_fault = fnext;
        end
        e.st   = nm;
        e.iso  = (nm == 1) || (nm == 2) || (nm == 4);
        e.isd  = (nm == 2);
        e.busy = (nm == 1) || (nm == 3);
        e.err  = (nm == 4);
    endtask

    task automatic step(input bit sw, input bit hw, input bit clr, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        if (w_auto) begin
            if (bus.isolate_o == w_iso) begin
                w_cnt = 0;
            end else begin
                w_cnt++;
                if (w_cnt > w_delay) begin
                    w_iso = bus.isolate_o;
                    w_cnt = 0;
                end
            end
        end
        rst = r;
        bus.sw_isolate_i = sw;
        bus.hw_fault_i   = hw;
        bus.clear_i      = clr;
        bus.isolated_i   = w_iso;
        model_step(sw, hw, clr, w_iso, r, e);
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        m_mode = 0; m_age = 1; m_fault = 1'b0;
        #1;
        chk("rst_state", bus.state_o, 0);
        chk("rst_isolate", bus.isolate_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done_irq", bus.done_irq_o, 0);
        chk("rst_err_irq", bus.err_irq_o, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every registered output against the expectation for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL stale_expectation: cycle %0d still queued at cycle %0d", e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            tests++;
            if (bus.state_o !== 3'(e.st) || bus.isolate_o !== e.iso || bus.isolated_o !== e.isd ||
                bus.busy_o !== e.busy || bus.error_o !== e.err || bus.done_irq_o !== e.done ||
                bus.err_irq_o !== e.eirq) begin
                fails++;
                $display("FAIL cycle_%0d outputs: got st=%0d iso=%b isd=%b busy=%b err=%b done=%b eirq=%b, expected st=%0d iso=%b isd=%b busy=%b err=%b done=%b eirq=%b",
                         cyc, bus.state_o, bus.isolate_o, bus.isolated_o, bus.busy_o, bus.error_o,
                         bus.done_irq_o, bus.err_irq_o, e.st, e.iso, e.isd, e.busy, e.err, e.done, e.eirq);
            end
        end
    end

    // Fail-safe boot instance: leaves reset isolating, completes on the wrapper ack.
    initial begin
        bus2.sw_isolate_i = 1'b1;
        bus2.hw_fault_i   = 1'b0;
        bus2.clear_i      = 1'b0;
        bus2.isolated_i   = 1'b0;
        #3;
        chk("ri_rst_state", bus2.state_o, 1);
        chk("ri_rst_isolate", bus2.isolate_o, 1);
        chk("ri_rst_busy", bus2.busy_o, 1);
        chk("ri_rst_err_irq", bus2.err_irq_o, 0);
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        bus2.isolated_i = 1'b1;
        @(posedge clk);
        #1;
        chk("ri_isolated_state", bus2.state_o, 2);
        chk("ri_done_irq", bus2.done_irq_o, 1);
        chk("ri_isolated_out", bus2.isolated_o, 1);
        @(posedge clk);
        #1;
        chk("ri_done_irq_single", bus2.done_irq_o, 0);
        chk("ri_hold_state", bus2.state_o, 2);
    end

    initial begin
        bit sw, hw, clr;
        rst = 1'b0;
        rst2 = 1'b0;
        bus.sw_isolate_i = 1'b0;
        bus.hw_fault_i   = 1'b0;
        bus.clear_i      = 1'b0;
        bus.isolated_i   = 1'b0;
        m_mode = 0; m_age = 1; m_fault = 1'b0;
        w_auto = 1'b1; w_delay = 3; w_cnt = 0; w_iso = 1'b0;
        #2;
        rst = 1'b1;
        rst2 = 1'b1;
        #1;
        chk("init_state", bus.state_o, 0);
        chk("init_isolate", bus.isolate_o, 0);
        chk("init_done_irq", bus.done_irq_o, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Software isolate with a 3-cycle wrapper, then release.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Wrapper never acknowledges: timeout, then clear with no request.
        w_auto = 1'b0; w_iso = 1'b0;
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        w_auto = 1'b1; w_cnt = 0;

        // Hardware fault pulse is sticky; clear during an active fault is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Ack on the last allowed cycle wins; one cycle later times out.
        w_delay = 15;
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        w_delay = 16;
        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        w_delay = 2;
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Unexpected ack drop while isolated.
        w_auto = 1'b0; w_iso = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        w_iso = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        w_auto = 1'b1; w_cnt = 0;

        // Reset in the middle of a release.
        w_delay = 10;
        repeat (16) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        reset_pulse();
        repeat (12) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with a misbehaving wrapper.
        sw = 1'b0;
        w_delay = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(19, 0) == 0) sw = ~sw;
            hw  = ($urandom_range(59, 0) == 0);
            clr = ($urandom_range(24, 0) == 0);
            if ($urandom_range(29, 0) == 0) w_delay = int'($urandom_range(20, 0));
            if ($urandom_range(79, 0) == 0) begin
                w_iso = ~w_iso;
                w_cnt = 0;
            end
            step(sw, hw, clr, 1'b0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
